// File: rtl/coeff_multiplier.sv
// Radix-4 shift-add multiplier (two multiplier bits per cycle, no DSP) feeding the
// Barrett reducer, with a one-entry valid/ready output hold and an operand range flag.
module coeff_multiplier #(
  parameter int Q_WIDTH    = 23,
  parameter int DATA_WIDTH = 48,
  parameter int Q          = 8380417
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  in_ready,
  input  logic [Q_WIDTH-1:0]    a_in,
  input  logic [Q_WIDTH-1:0]    b_in,
  output logic [DATA_WIDTH-1:0] product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  range_err
);

  // Handshake: an op is taken on a rising edge where start & in_ready; a product is
  // handed off on a rising edge where out_valid & out_ready. Nothing else moves data.

  localparam int DIGITS = (Q_WIDTH + 1) / 2;
  localparam int PP_W   = Q_WIDTH + 2;
  localparam int B_W    = 2 * DIGITS;
  localparam int IT_W   = 4;
  localparam logic [Q_WIDTH-1:0] Q_VAL   = Q_WIDTH'(Q);
  localparam logic [IT_W-1:0]    IT_LAST = IT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_next;

  logic [Q_WIDTH-1:0]    a_reg;
  logic [PP_W-1:0]       a3_reg;
  logic [B_W-1:0]        b_sh;
  logic [DATA_WIDTH-1:0] acc;
  logic [IT_W-1:0]       iter;
  logic                  range_err_next;

  logic                  accept;
  logic                  last_digit;
  logic [PP_W-1:0]       pp;
  logic [DATA_WIDTH-1:0] sum;

  assign accept     = start & in_ready;
  assign last_digit = (iter == IT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = MULT;
      MULT: if (last_digit) state_next = HOLD;
      HOLD: if (out_ready) state_next = accept ? MULT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Digit select: 3a is precomputed at accept so each cycle is a single add
  always_comb begin
    pp = '0;
    case (b_sh[1:0])
      2'd0: pp = '0;
      2'd1: pp = PP_W'(a_reg);
      2'd2: pp = PP_W'({a_reg, 1'b0});
      2'd3: pp = a3_reg;
      default: pp = '0;
    endcase
  end

  assign sum = acc + (DATA_WIDTH'(pp) << {iter, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg          <= '0;
      a3_reg         <= '0;
      b_sh           <= '0;
      acc            <= '0;
      iter           <= '0;
      range_err_next <= 1'b0;
      product        <= '0;
      out_valid      <= 1'b0;
      range_err      <= 1'b0;
    end else if (accept) begin
      a_reg          <= a_in;
      a3_reg         <= PP_W'(a_in) + PP_W'({a_in, 1'b0});
      b_sh           <= B_W'(b_in);
      acc            <= '0;
      iter           <= '0;
      range_err_next <= (a_in >= Q_VAL) | (b_in >= Q_VAL);
      out_valid      <= 1'b0;
      range_err      <= 1'b0;
    end else if (state == MULT) begin
      acc  <= sum;
      b_sh <= b_sh >> 2;
      iter <= iter + 1'b1;
      if (last_digit) begin
        product   <= sum;
        range_err <= range_err_next;
        out_valid <= 1'b1;
      end
    end else if ((state == HOLD) && out_ready) begin
      out_valid <= 1'b0;
      range_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coeff_multiplier.sv
// Self-checking bench for coeff_multiplier: directed scenarios plus a randomized run
// against a cycle-count model of latency, handshake and exact products.
module tb_coeff_multiplier;

  localparam int QW = 23;
  localparam int DW = 48;
  localparam longint unsigned QM = 64'd8380417;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_ready;
  logic [QW-1:0] a_in;
  logic [QW-1:0] b_in;
  logic [DW-1:0] product;
  logic          out_valid;
  logic          out_ready;
  logic          range_err;

  int n_checks;
  int n_fail;

  logic [DW-1:0] exp_q[$];
  logic          exp_r[$];

  coeff_multiplier #(.Q_WIDTH(QW), .DATA_WIDTH(DW), .Q(8380417)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .product(product), .out_valid(out_valid),
    .out_ready(out_ready), .range_err(range_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_prod(input logic [QW-1:0] a, input logic [QW-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[DW-1:0];
  endfunction

  function automatic logic model_rerr(input logic [QW-1:0] a, input logic [QW-1:0] b);
    return (longint'(a) >= QM) || (longint'(b) >= QM);
  endfunction

  function automatic logic [QW-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return QW'(QM - 1);
      1: return QW'(QM);
      2: return {QW{1'b1}};
      3: return QW'($urandom_range(0, 15));
      default: return QW'($urandom);
    endcase
  endfunction

  // Driver: waits (bounded) for in_ready, presents one op for one edge
  task automatic start_op(input logic [QW-1:0] a, input logic [QW-1:0] b);
    bit ok;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_op_timeout: in_ready=%b required 1", in_ready);
    end
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of negedges until out_valid is seen (0 = never within budget)
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      start     = 1'($urandom);
      out_ready = 1'($urandom);
      a_in      = QW'($urandom);
      b_in      = QW'($urandom);
      @(negedge clk);
    end
    n_checks++;
    if ({product, out_valid, range_err, in_ready} !== {48'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: product=%0d valid=%b rerr=%b in_ready=%b required 0/0/0/1",
               product, out_valid, range_err, in_ready);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({product, out_valid, range_err, in_ready} !== {48'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_idle: product=%0d valid=%b rerr=%b in_ready=%b required 0/0/0/1",
               product, out_valid, range_err, in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    start_op(23'd3, 23'd5);
    wait_valid(lat);
    n_checks++;
    if (lat !== 12) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles required 12", lat);
    end
    n_checks++;
    if (product !== 48'd15 || range_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_product: product=%0d rerr=%b required 15/0", product, range_err);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_single_valid: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_max();
    int lat;
    out_ready = 1'b1;
    start_op(QW'(QM - 1), QW'(QM - 1));
    wait_valid(lat);
    n_checks++;
    if (lat !== 12 || product !== 48'h3FE004000000 || range_err !== 1'b0) begin
      n_fail++;
      $display("FAIL max_product: lat=%0d product=%h rerr=%b required 12/3fe004000000/0",
               lat, product, range_err);
    end
    @(negedge clk);
    start_op(23'd0, QW'(QM - 1));
    wait_valid(lat);
    n_checks++;
    if (lat !== 12 || product !== 48'd0) begin
      n_fail++;
      $display("FAIL zero_product: lat=%0d product=%0d required 12/0", lat, product);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    out_ready = 1'b0;
    start_op(23'd1000, 23'd7);
    wait_valid(lat);
    n_checks++;
    if (lat !== 12 || product !== 48'd7000) begin
      n_fail++;
      $display("FAIL bp_product: lat=%0d product=%0d required 12/7000", lat, product);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      start = 1'($urandom);
      a_in  = QW'($urandom);
      b_in  = QW'($urandom);
      @(negedge clk);
      if (product !== 48'd7000 || out_valid !== 1'b1 || in_ready !== 1'b0 || range_err !== 1'b0)
        bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles required 0 (product=%0d valid=%b)",
               bad, product, out_valid);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    a_in      = 23'd2;
    b_in      = 23'd2;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_consume_accept: valid=%b required 0", out_valid);
    end
    wait_valid(lat);
    n_checks++;
    if (lat !== 12 || product !== 48'd4) begin
      n_fail++;
      $display("FAIL bp_next_product: lat=%0d product=%0d required 12/4", lat, product);
    end
    @(negedge clk);
  endtask

  task automatic test_range();
    int lat;
    out_ready = 1'b1;
    start_op(QW'(QM), 23'd2);
    wait_valid(lat);
    n_checks++;
    if (lat !== 12 || product !== 48'd16760834 || range_err !== 1'b1) begin
      n_fail++;
      $display("FAIL range_flag: lat=%0d product=%0d rerr=%b required 12/16760834/1",
               lat, product, range_err);
    end
    @(negedge clk);
    n_checks++;
    if (range_err !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL range_clear: rerr=%b valid=%b required 0/0", range_err, out_valid);
    end
    start_op(23'd1, 23'd1);
    wait_valid(lat);
    n_checks++;
    if (lat !== 12 || product !== 48'd1 || range_err !== 1'b0) begin
      n_fail++;
      $display("FAIL range_next: lat=%0d product=%0d rerr=%b required 12/1/0", lat, product, range_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    int stray;
    out_ready = 1'b1;
    start_op(23'd5, 23'd9);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || product !== 48'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b product=%0d in_ready=%b required 0/0/1",
               out_valid, product, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL mid_reset_stray: %0d valid cycles required 0", stray);
    end
    start_op(23'd4194304, 23'd4);
    wait_valid(lat);
    n_checks++;
    if (lat !== 12 || product !== 48'd16777216) begin
      n_fail++;
      $display("FAIL mid_reset_recover: lat=%0d product=%0d required 12/16777216", lat, product);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int issued;
    int seen;
    int last_t;
    logic [DW-1:0] e;
    out_ready = 1'b1;
    a_in      = pick_operand();
    b_in      = pick_operand();
    exp_q.push_back(model_prod(a_in, b_in));
    start  = 1'b1;
    issued = 1;
    seen   = 0;
    last_t = 0;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front();
        n_checks++;
        if (product !== e) begin
          n_fail++;
          $display("FAIL b2b_product: got %0d required %0d", product, e);
        end
        if (seen > 0) begin
          n_checks++;
          if (t - last_t != 13) begin
            n_fail++;
            $display("FAIL b2b_interval: got %0d cycles required 13", t - last_t);
          end
        end
        last_t = t;
        seen++;
      end
      if (in_ready === 1'b1) begin
        if (issued < 5) begin
          a_in = pick_operand();
          b_in = pick_operand();
          exp_q.push_back(model_prod(a_in, b_in));
          issued++;
        end else begin
          start = 1'b0;
        end
      end
      if (seen == 5) break;
    end
    start = 1'b0;
    n_checks++;
    if (seen != 5) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d products required 5", seen);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Randomized run: model tracks cycles remaining until a result and whether one is held
  task automatic test_random();
    int  cnt;
    bit  mv;
    bit  exp_ir;
    logic [DW-1:0] e;
    cnt = 0;
    mv  = 0;
    for (int t = 0; t < 1500; t++) begin
      start     = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a_in      = pick_operand();
      b_in      = pick_operand();
      #1;
      exp_ir = (cnt == 0) && (!mv || out_ready);
      n_checks++;
      if (out_valid !== mv || in_ready !== exp_ir) begin
        n_fail++;
        $display("FAIL rand_handshake t=%0d: valid=%b in_ready=%b required %b/%b",
                 t, out_valid, in_ready, mv, exp_ir);
      end
      if (mv) begin
        n_checks++;
        if (product !== exp_q[0] || range_err !== exp_r[0]) begin
          n_fail++;
          $display("FAIL rand_product t=%0d: product=%0d rerr=%b required %0d/%b",
                   t, product, range_err, exp_q[0], exp_r[0]);
        end
      end
      if (mv && out_ready) begin
        e  = exp_q.pop_front();
        void'(exp_r.pop_front());
        mv = 0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) mv = 1;
      end else if (exp_ir && start) begin
        exp_q.push_back(model_prod(a_in, b_in));
        exp_r.push_back(model_rerr(a_in, b_in));
        cnt = 12;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    start     = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coeff_multiplier.md
Name: coeff_multiplier

Overview:
- Sequential shift-add modular-arithmetic front end for the fixed modulus Q = 8380417: multiplies two 23-bit coefficients into a 48-bit product that feeds the Barrett reduction stage's 48-bit data input.
- Uses no DSP: radix-4, two multiplier bits per cycle.
- Provides a one-entry output hold with valid/ready so the downstream reducer can backpressure.
- Flags operands that are not already reduced (≥ Q).

Parameters:
- Q_WIDTH, 23, operand width; the multiplier sequence is sized for 23 bits (12 radix-4 digits).
- DATA_WIDTH, 48, product/accumulator width.
- Q, 8380417, modulus used only for the operand range check.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a multiply; accepted only when in_ready=1
- in_ready  output  1  combinational: (state==IDLE) | (state==HOLD & out_ready)
- a_in  input  Q_WIDTH  multiplicand, sampled on accept
- b_in  input  Q_WIDTH  multiplier, sampled on accept
- product  output  DATA_WIDTH  a*b, registered, valid while out_valid=1
- out_valid  output  1  registered; product available
- out_ready  input  1  downstream accepts product on an edge where out_valid=1
- range_err  output  1  registered; (a≥Q)|(b≥Q) for the op whose product is presented

Behaviour:
- Reset (async, rst_n=0): state=IDLE, product=0, out_valid=0, range_err=0, internal a/3a/b-shift/acc/iter regs=0. Asserting reset mid-operation aborts the operation. No partial result is ever presented.
- accept = start & in_ready. On accept:
  - latch a_reg=a_in, a3_reg=3*a_in (25 bits), b_sh=b_in zero-extended to 24 bits, acc=0, iter=0.
  - compute range_err_next=(a_in≥Q)|(b_in≥Q).
  - state<=MULT.
  - If accept happens in HOLD, out_valid<=0 on the same edge (the current product is consumed).
- MULT, one digit per cycle:
  - d=b_sh[1:0]; pp = 0, a_reg, a_reg<<1, or a3_reg for d = 0..3.
  - acc<=acc+(pp<<(2*iter)); b_sh<=b_sh>>2; iter<=iter+1.
  - On iter==11 (12th MULT cycle): product<=final sum (acc+pp term), range_err<=range_err_next, out_valid<=1, state<=HOLD.
- Latency: out_valid is high exactly 12 cycles after the accepting edge. Throughput is one product per 13 cycles when out_ready is held high and start is held high.
- HOLD: product, range_err and out_valid stay stable until an edge with out_ready=1.
  - On that edge, if start=1 a new op is accepted (→MULT). Otherwise → IDLE with out_valid<=0.
- start while in MULT, or in HOLD with out_ready=0: ignored, no state change, in_ready=0.
- out_ready while out_valid=0: ignored.
- Width rules:
  - pp ≤ 25 bits; shift ≤ 22.
  - product < 2^46, so product[47:46]=0 always and no overflow in the 48-bit acc.
  - a_in/b_in ≥ Q are still multiplied exactly; only range_err is raised.
- range_err is meaningful only while out_valid=1. It is cleared to 0 when the product is consumed without a new accept.

Test Plan:
1. Reset: hold rst_n=0 with random inputs → product=0, out_valid=0, range_err=0, in_ready=1. Release, drive no start → outputs unchanged.
2. a=3, b=5, out_ready=1 → out_valid rises exactly 12 cycles after accept, product=15, range_err=0, single-cycle valid, then IDLE.
3. a=b=8380416 (Q-1) → product=70231372333056 (0x3FE004000000), range_err=0. Also a=0, b=8380416 → product=0.
4. Backpressure: complete a=1000, b=7 with out_ready=0 for 20 cycles → product=7000 held stable, start pulses ignored (in_ready=0). Then out_ready=1 & start=1 with a=2, b=2 in one cycle → new op accepted, product=4 12 cycles later.
5. Range: a=8380417, b=2 → product=16760834, range_err=1. Next op a=1, b=1 → product=1, range_err=0.
6. Reset mid-operation: assert rst_n=0 at iteration 5 → out_valid=0 immediately, no stray valid after release. Then a=4194304, b=4 → product=16777216.
